// File: rtl/button_conditioner_if.sv
// Button-side interface: raw active-low buttons in, single-cycle game requests out.
interface button_conditioner_if;
  logic btn_move_n;
  logic btn_select_n;
  logic move;
  logic select;

  // Driver of the raw buttons and consumer of the requests
  modport master (
    output btn_move_n,
    output btn_select_n,
    input  move,
    input  select
  );

  // Conditioner side
  modport slave (
    input  btn_move_n,
    input  btn_select_n,
    output move,
    output select
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and pulse-encodes two push-buttons; move auto-repeats while held.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic               clk,
  input  logic               rst,
  button_conditioner_if.slave bus
);

  localparam int unsigned NBTN     = 2;
  localparam int unsigned BTN_MOVE = 0;
  localparam int unsigned BTN_SEL  = 1;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned RPT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } state_t;

  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  pressed;
  state_t           state [NBTN];
  logic [CNT_W-1:0] cnt   [NBTN];
  logic [CNT_W-1:0] cnt_inc_c   [NBTN];
  logic [NBTN-1:0]  cnt_reach_c;
  logic [NBTN-1:0]  press_evt;

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_inc_c;
  logic             rpt_first_done;
  logic             rpt_hit_c;
  logic             rpt_evt;

  // Two-flop synchronizers; stored polarity is "pressed" (raw low)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      pressed <= '0;
    end else begin
      sync1   <= ~{bus.btn_select_n, bus.btn_move_n};
      pressed <= sync1;
    end
  end

  // Saturating stability-counter increment and terminal-count detect
  always_comb begin
    for (int b = 0; b < NBTN; b++) begin
      cnt_inc_c[b]   = (cnt[b] == {CNT_W{1'b1}}) ? cnt[b] : cnt[b] + CNT_W'(1);
      cnt_reach_c[b] = ((CNT_W+1)'(cnt[b]) + (CNT_W+1)'(1)) >= (CNT_W+1)'(DEBOUNCE_CYCLES);
    end
  end

  // Per-button debounce FSM; press_evt marks the cycle a press is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NBTN; b++) begin
        state[b] <= IDLE;
        cnt[b]   <= '0;
      end
      press_evt <= '0;
    end else begin
      press_evt <= '0;
      for (int b = 0; b < NBTN; b++) begin
        case (state[b])
          IDLE: begin
            if (pressed[b]) begin
              state[b] <= CONFIRM_PRESS;
              cnt[b]   <= CNT_W'(1);
            end
          end
          CONFIRM_PRESS: begin
            if (!pressed[b]) begin
              state[b] <= IDLE;
              cnt[b]   <= '0;
            end else if (cnt_reach_c[b]) begin
              state[b]     <= HELD;
              cnt[b]       <= '0;
              press_evt[b] <= 1'b1;
            end else begin
              cnt[b] <= cnt_inc_c[b];
            end
          end
          HELD: begin
            if (!pressed[b]) begin
              state[b] <= CONFIRM_RELEASE;
              cnt[b]   <= CNT_W'(1);
            end
          end
          CONFIRM_RELEASE: begin
            if (pressed[b]) begin
              state[b] <= HELD;
              cnt[b]   <= '0;
            end else if (cnt_reach_c[b]) begin
              state[b] <= IDLE;
              cnt[b]   <= '0;
            end else begin
              cnt[b] <= cnt_inc_c[b];
            end
          end
          default: begin
            state[b] <= IDLE;
            cnt[b]   <= '0;
          end
        endcase
      end
    end
  end

  // Repeat timer target: initial delay first, then the steady period
  always_comb begin
    rpt_inc_c = (rpt_cnt == {RPT_W{1'b1}}) ? rpt_cnt : rpt_cnt + RPT_W'(1);
    rpt_hit_c = ((RPT_W+1)'(rpt_cnt) + (RPT_W+1)'(1)) >=
                (rpt_first_done ? (RPT_W+1)'(REPEAT_PERIOD) : (RPT_W+1)'(REPEAT_DELAY));
  end

  // Move auto-repeat; runs only while move stays in HELD, cleared otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt        <= '0;
      rpt_first_done <= 1'b0;
      rpt_evt        <= 1'b0;
    end else begin
      rpt_evt <= 1'b0;
      if (state[BTN_MOVE] == HELD && pressed[BTN_MOVE]) begin
        if (rpt_hit_c) begin
          rpt_cnt        <= '0;
          rpt_first_done <= 1'b1;
          rpt_evt        <= 1'b1;
        end else begin
          rpt_cnt <= rpt_inc_c;
        end
      end else begin
        rpt_cnt        <= '0;
        rpt_first_done <= 1'b0;
      end
    end
  end

  // Output stage: select wins a same-cycle collision, move is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.move   <= 1'b0;
      bus.select <= 1'b0;
    end else begin
      bus.select <= press_evt[BTN_SEL];
      bus.move   <= (press_evt[BTN_MOVE] | rpt_evt) & ~press_evt[BTN_SEL];
    end
  end

endmodule
